// File: rtl/poly1305_block_formatter.sv
// Packs AAD and ciphertext words into 130-bit Poly1305 blocks, then appends the length block.
// Optional FMT_CHECK_EN adds a sticky proto_err output that flags input protocol violations.
module poly1305_block_formatter #(
    parameter int unsigned COUNT_W = 64
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [127:0]   in_data,
    input  logic [4:0]     in_bytes,
    input  logic           in_last,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [129:0]   out_block,
    output logic           out_last,
`ifdef FMT_CHECK_EN
    output logic           proto_err,
`endif
    output logic           busy
);

    typedef enum logic [2:0] {StIdle, StAad, StCt, StLen, StDone} state_t;

    state_t               state_q, state_d;
    logic [COUNT_W-1:0]   aad_cnt_q, aad_cnt_d;
    logic [COUNT_W-1:0]   ct_cnt_q, ct_cnt_d;
    logic                 out_valid_q, out_valid_d;
    logic [129:0]         out_block_q, out_block_d;
    logic                 out_last_q, out_last_d;

    logic                 can_load;
    logic                 accept;
    logic [127:0]         masked_data;
    logic [63:0]          aad_len64;
    logic [63:0]          ct_len64;

    // The output register can take a new block when empty or draining this cycle.
    assign can_load  = !out_valid_q || out_ready;
    assign in_ready  = ((state_q == StAad) || (state_q == StCt)) && can_load;
    assign accept    = in_valid && in_ready;
    assign aad_len64 = 64'(aad_cnt_q);
    assign ct_len64  = 64'(ct_cnt_q);

    assign out_valid = out_valid_q;
    assign out_block = out_block_q;
    assign out_last  = out_last_q;
    assign busy      = (state_q != StIdle);

    always_comb begin
        masked_data = '0;
        for (int k = 0; k < 16; k++) begin
            if (5'(k) < in_bytes) begin
                masked_data[8*k +: 8] = in_data[8*k +: 8];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        aad_cnt_d   = aad_cnt_q;
        ct_cnt_d    = ct_cnt_q;
        out_valid_d = out_valid_q && !out_ready;
        out_block_d = out_block_q;
        out_last_d  = out_last_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d   = StAad;
                    aad_cnt_d = '0;
                    ct_cnt_d  = '0;
                end
            end
            StAad: begin
                if (accept) begin
                    aad_cnt_d = aad_cnt_q + COUNT_W'(in_bytes);
                    if (in_last) begin
                        state_d = StCt;
                    end
                end
            end
            StCt: begin
                if (accept) begin
                    ct_cnt_d = ct_cnt_q + COUNT_W'(in_bytes);
                    if (in_last) begin
                        state_d = StLen;
                    end
                end
            end
            StLen: begin
                if (can_load) begin
                    out_block_d = {2'b01, ct_len64, aad_len64};
                    out_last_d  = 1'b1;
                    out_valid_d = 1'b1;
                    state_d     = StDone;
                end
            end
            StDone: begin
                if (out_valid_q && out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // A zero-byte word only closes a segment; it never produces a block.
        if (accept && (in_bytes != 5'd0)) begin
            out_block_d = {2'b01, masked_data};
            out_last_d  = 1'b0;
            out_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            aad_cnt_q   <= '0;
            ct_cnt_q    <= '0;
            out_valid_q <= 1'b0;
            out_block_q <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            aad_cnt_q   <= aad_cnt_d;
            ct_cnt_q    <= ct_cnt_d;
            out_valid_q <= out_valid_d;
            out_block_q <= out_block_d;
            out_last_q  <= out_last_d;
        end
    end

`ifdef FMT_CHECK_EN
    logic err_q, err_d;
    logic violation;

    always_comb begin
        violation = 1'b0;
        if (accept && ((in_bytes > 5'd16) || (!in_last && (in_bytes != 5'd16)))) begin
            violation = 1'b1;
        end
        if (in_valid && ((state_q == StIdle) || (state_q == StLen) || (state_q == StDone))) begin
            violation = 1'b1;
        end
        err_d = ((state_q == StIdle) && start) ? 1'b0 : err_q;
        err_d = err_d | violation;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign proto_err = err_q;
`endif

endmodule
